// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/result bundle
// for the iterative execute-stage multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTHxWIDTH multiplier, one multiplier bit
// per cycle, signed handled by magnitude multiply plus final negate.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    seq_multiplier_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   load, step, fin;

    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic [WIDTH-1:0]   res_hi_q;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    fin     = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // |MIN| wraps to itself, which is the correct unsigned magnitude
    always_comb begin
        a_neg = bus.is_signed & bus.op_a[WIDTH-1];
        b_neg = bus.is_signed & bus.op_b[WIDTH-1];
        a_abs = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
        b_abs = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    end

    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_nx = {sum, acc_q[WIDTH-1:1]};
        prod   = neg_q ? (~acc_nx + 1'b1) : acc_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                cnt_q    <= '0;
                mcand_q  <= a_abs;
                mplier_q <= b_abs;
                acc_q    <= '0;
                neg_q    <= a_neg ^ b_neg;
            end else if (step) begin
                cnt_q    <= fin ? '0 : cnt_q + 1'b1;
                mplier_q <= mplier_q >> 1;
                acc_q    <= acc_nx;
            end
            if (fin) begin
                res_lo_q <= prod[WIDTH-1:0];
                res_hi_q <= prod[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed table plus handshake/reset sequences and random
// operands against a 64-bit reference product.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_multiplier_if #(.WIDTH(32)) bus ();

    seq_multiplier #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s,
        input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx;
        ax = s ? {{32{a[31]}}, a} : {32'b0, a};
        bx = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    function automatic logic [63:0] result();
        return {bus.result_hi, bus.result_lo};
    endfunction

    // Call at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic s, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [63:0] res, output int lat,
                         output int bc, output int both);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        lat  = 0;
        bc   = 0;
        both = 0;
        @(posedge clk);
        while (lat < 100) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy && bus.done) both++;
            if (bus.done) break;
            if (bus.busy) bc++;
            @(posedge clk);
            lat++;
        end
        res = result();
    endtask

    initial begin
        logic [63:0] res;
        int lat, bc, both, ca, cb, ndone;
        logic s;
        logic [31:0] a, b;

        vecs.push_back('{"u_3x5", 1'b0, 32'd3, 32'd5, 64'h0000000F});
        vecs.push_back('{"s_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5,
                         64'hFFFFFFFF_FFFFFFF1});
        vecs.push_back('{"u_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         64'hFFFFFFFE_00000001});
        vecs.push_back('{"s_min2", 1'b1, 32'h80000000, 32'h80000000,
                         64'h40000000_00000000});
        vecs.push_back('{"s_minx1", 1'b1, 32'h80000000, 32'd1,
                         64'hFFFFFFFF_80000000});
        vecs.push_back('{"s_zero", 1'b1, 32'd0, 32'h12345678, 64'd0});
        vecs.push_back('{"s_m1m1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         64'd1});
        vecs.push_back('{"u_big", 1'b0, 32'h80000000, 32'd2,
                         64'h00000001_00000000});
        vecs.push_back('{"s_maxsq", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         64'h3FFFFFFF_00000001});
        vecs.push_back('{"s_m2xmax", 1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF,
                         64'hFFFFFFFF_00000002});
        vecs.push_back('{"u_fdx5", 1'b0, 32'hFFFFFFFD, 32'd5,
                         64'h00000004_FFFFFFF1});

        rst = 1'b1;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_result", result(), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, res, lat, bc, both);
            chk({vecs[i].name, "_prod"}, res, vecs[i].p);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd32);
            chk({vecs[i].name, "_busy"}, 64'(bc), 64'd32);
            chk({vecs[i].name, "_overlap"}, 64'(both), 64'd0);
            @(negedge clk);
            chk({vecs[i].name, "_done1"}, {63'd0, bus.done}, 64'd0);
            chk({vecs[i].name, "_hold"}, result(), vecs[i].p);
        end

        // start and operand changes while running are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a = 32'h10;
        bus.op_b = 32'h10;
        ndone = 0;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start = (k == 10);
            if (k == 10) begin
                bus.op_a = 32'h55;
                bus.is_signed = 1'b1;
            end
            if (k == 11) bus.op_b = 32'hFFFFFFFF;
            if (bus.done) begin
                ndone++;
                res = result();
                chk("ign_done_cycle", 64'(k), 64'd33);
            end
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_prod", res, 64'd256);
        chk("ign_hold", result(), 64'd256);

        // back-to-back: second start in the done cycle
        do_op(1'b0, 32'd3, 32'd4, res, lat, bc, both);
        ca = cyc;
        chk("b2b_first", res, 64'd12);
        do_op(1'b0, 32'd7, 32'd6, res, lat, bc, both);
        cb = cyc;
        chk("b2b_second", res, 64'd42);
        chk("b2b_gap", 64'(cb - ca), 64'd33);
        chk("b2b_busy", 64'(bc), 64'd32);

        // reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a = 32'd9;
        bus.op_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_result", result(), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        do_op(1'b0, 32'd2, 32'd2, res, lat, bc, both);
        chk("rst_after", res, 64'd4);
        chk("rst_after_lat", 64'(lat), 64'd32);

        for (int n = 0; n < 1000; n++) begin
            s = n[0];
            a = $urandom;
            b = $urandom;
            if (n % 50 == 7) a = 32'h80000000;
            if (n % 50 == 8) b = 32'hFFFFFFFF;
            @(negedge clk);
            do_op(s, a, b, res, lat, bc, both);
            if (lat >= 100) chk("rand_timeout", 64'(lat), 64'd32);
            chk($sformatf("rand_%0d_s%0d_%h_%h", n, s, a, b),
                res, ref_prod(s, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
